// File: rtl/rv_pkg.sv
// Shared fetch-path types and constants.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] RV_NOP = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] data;
    logic            err;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched entries; flush wins over push and pop.
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = fetch_entry_t,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  T              push_data_i,
  input  logic          pop_i,
  output T              head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  T              mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: credit-limited sequential fetch, in-order
// response buffering, redirect flush with in-flight drop accounting.
module fetch_prefetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [ILEN-1:0] mem_rsp_data,
  input  logic            mem_rsp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_pc,
  output logic [ILEN-1:0] inst_data,
  output logic            inst_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  // Drop counter is sized for several flushes stacked on top of a full window.
  localparam int unsigned DW = CW + 3;
  localparam int unsigned SW = CW + 1;

  fetch_state_t    state_q, state_d;
  logic            req_valid_q, req_valid_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [DW-1:0]   drop_q, drop_d;
  logic            fault_pend_q, fault_pend_d;

  logic            req_acc;
  logic            rsp_live;
  logic            rsp_drop;
  logic            redir_misaligned;
  logic [CW-1:0]   count_nxt;
  logic            credit_ok;

  logic            fifo_push;
  logic            fifo_pop;
  fetch_entry_t    fifo_wdata;
  fetch_entry_t    fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  assign req_acc          = req_valid_q && mem_req_ready;
  assign rsp_drop         = mem_rsp_valid && (drop_q != '0);
  assign rsp_live         = mem_rsp_valid && (drop_q == '0);
  assign redir_misaligned = (redirect_pc[1:0] != 2'b00);

  // Entry source: a pending misaligned-redirect fault, else a live response.
  always_comb begin
    fifo_push  = fault_pend_q || rsp_live;
    fifo_pop   = inst_valid && inst_ready;
    fifo_wdata = '{pc: rsp_pc_q, data: mem_rsp_data, err: mem_rsp_err};
    if (fault_pend_q) fifo_wdata = '{pc: rsp_pc_q, data: RV_NOP, err: 1'b1};
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Next-state FSM: faults halt fetch, only an aligned redirect restarts it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (redirect_valid) begin
          if (redir_misaligned) state_d = HALT;
        end else if (rsp_live && mem_rsp_err) begin
          state_d = HALT;
        end
      end
      HALT: begin
        if (redirect_valid && !redir_misaligned) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Counters, PCs and request issue; redirect overrides every other update.
  always_comb begin
    inflight_d   = inflight_q + CW'(req_acc) - CW'(rsp_live);
    drop_d       = drop_q - DW'(rsp_drop);
    fetch_pc_d   = req_acc ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    rsp_pc_d     = fifo_push ? rsp_pc_q + XLEN'(4) : rsp_pc_q;
    fault_pend_d = 1'b0;
    count_nxt    = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    if (redirect_valid) begin
      // Everything still outstanding after this edge belongs to the old stream.
      drop_d       = drop_q + DW'(inflight_q) + DW'(req_acc) - DW'(mem_rsp_valid);
      inflight_d   = '0;
      fetch_pc_d   = redirect_pc;
      rsp_pc_d     = redirect_pc;
      fault_pend_d = redir_misaligned;
      count_nxt    = '0;
    end
    credit_ok = (SW'(inflight_d) + SW'(count_nxt) < SW'(DEPTH));
    if (redirect_valid) begin
      req_valid_d = (state_d == RUN);
    end else if (req_valid_q && !req_acc) begin
      // An offered request is held until taken, even if a fault halts fetch.
      req_valid_d = 1'b1;
    end else begin
      req_valid_d = (state_d == RUN) && credit_ok;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      req_valid_q  <= 1'b0;
      fetch_pc_q   <= RESET_PC;
      rsp_pc_q     <= RESET_PC;
      inflight_q   <= '0;
      drop_q       <= '0;
      fault_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_valid_q  <= req_valid_d;
      fetch_pc_q   <= fetch_pc_d;
      rsp_pc_q     <= rsp_pc_d;
      inflight_q   <= inflight_d;
      drop_q       <= drop_d;
      fault_pend_q <= fault_pend_d;
    end
  end

  // Credits guarantee a free slot for every live push.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_full && fifo_push && !fifo_pop && !redirect_valid));

  assign mem_req_valid = req_valid_q;
  assign mem_req_addr  = fetch_pc_q;
  assign inst_valid    = !fifo_empty;
  assign inst_pc       = inst_valid ? fifo_head.pc : '0;
  assign inst_data     = inst_valid ? fifo_head.data : RV_NOP;
  assign inst_err      = inst_valid && fifo_head.err;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Randomized bench for fetch_prefetch_unit with a memory model and an
// expected-instruction-stream reference.
module tb_fetch_prefetch_unit;
  import rv_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_err;

  fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_err    (mem_rsp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .inst_err       (inst_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          epoch = 0;
  int          last_due = 0;
  int          live = 0;
  int          p_ready = 100, p_iready = 100, p_redir = 0;
  int          lat_min = 1, lat_max = 1;
  logic [31:0] exp_req = 32'h0;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] fault_pc = 32'h0;
  logic [31:0] last_err_pc = 32'hDEAD_BEEF;
  bit          halted = 0, fault_mode = 0, fault_done = 0;
  bit          prev_valid = 0, prev_acc = 0, redir_prev = 0;
  logic [31:0] prev_addr = 32'h0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic errfn(input logic [31:0] a);
    return (a == 32'h40) || (a[31:8] == 24'h0000EE);
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] r;
    r = $urandom;
    case ($urandom % 5)
      0:       return {20'h0, r[11:2], 2'b00};
      1:       return 32'h0000_EE00 + {24'h0, r[7:2], 2'b00};
      2:       return 32'hFFFF_FFF0;
      3:       return {20'h0, r[11:2], 2'b01 | r[1:0]};
      default: return {r[31:2], 2'b00};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: check current outputs, drive inputs, advance the reference.
  task automatic step(input bit frc, input logic [31:0] fpc);
    mreq_t r;
    bit    rsp_v, acc, pop;
    int    d;
    if (!inst_valid) chk("idle_nop", inst_data, NOP);
    if (redir_prev) chk("flush_empty", inst_valid, 1'b0);
    if (prev_valid && !prev_acc && !redir_prev) begin
      chk("req_hold", mem_req_valid, 1'b1);
      chk("req_addr_hold", mem_req_addr, prev_addr);
    end
    if (halted) chk("halt_no_req", mem_req_valid, !redir_prev && prev_valid && !prev_acc);

    redirect_valid = frc || (($urandom % 1000) < p_redir);
    redirect_pc    = frc ? fpc : rand_target();
    mem_req_ready  = ($urandom % 100) < p_ready;
    inst_ready     = ($urandom % 100) < p_iready;
    rsp_v = (memq.size() > 0) && (memq[0].due <= cyc);
    if (rsp_v) begin
      r = memq.pop_front();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = memfn(r.addr);
      mem_rsp_err   = errfn(r.addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = $urandom;
      mem_rsp_err   = 1'($urandom);
    end

    acc = mem_req_valid && mem_req_ready;
    pop = inst_valid && inst_ready;

    if (rsp_v && r.epoch == epoch && !redirect_valid && errfn(r.addr)) halted = 1;

    if (pop && !redirect_valid) begin
      if (fault_mode) begin
        if (fault_done) chk("fault_extra", inst_valid, 1'b0);
        else begin
          chk("fault_pc", inst_pc, fault_pc);
          chk("fault_data", inst_data, NOP);
          chk("fault_err", inst_err, 1'b1);
          fault_done = 1;
        end
      end else begin
        chk("inst_pc", inst_pc, exp_pc);
        chk("inst_data", inst_data, memfn(exp_pc));
        chk("inst_err", inst_err, errfn(exp_pc));
        if (inst_err) last_err_pc = inst_pc;
        exp_pc = exp_pc + 32'd4;
        live--;
      end
    end

    if (acc) begin
      chk("req_addr", mem_req_addr, exp_req);
      exp_req = exp_req + 32'd4;
      d = cyc + $urandom_range(lat_max, lat_min);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      memq.push_back('{mem_req_addr, epoch, d});
      if (!redirect_valid) begin
        live++;
        chk("credit_window", live > DEPTH, 1'b0);
      end
    end

    if (redirect_valid) begin
      epoch++;
      exp_req    = redirect_pc;
      exp_pc     = redirect_pc;
      live       = 0;
      fault_mode = (redirect_pc[1:0] != 2'b00);
      fault_pc   = redirect_pc;
      fault_done = 0;
      halted     = fault_mode;
    end

    prev_valid = mem_req_valid;
    prev_acc   = acc;
    prev_addr  = mem_req_addr;
    redir_prev = redirect_valid;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'h0;
    mem_rsp_err    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_req_addr", mem_req_addr, 32'h0);
    chk("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_data", inst_data, NOP);
    chk("rst_inst_err", inst_err, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming: always-ready memory, 1-cycle latency, consumer always ready.
    for (int i = 0; i < 10; i++) begin
      if (i >= 2) chk("no_bubble", inst_valid, 1'b1);
      step(0, 32'h0);
    end

    // Consumer stall: the credit window fills and requests stop.
    p_iready = 0;
    for (int i = 0; i < 10; i++) step(0, 32'h0);
    chk("stall_live", live, DEPTH);
    chk("stall_req_off", mem_req_valid, 1'b0);
    chk("stall_head", inst_valid, 1'b1);

    // Resume; fetch runs into the fault at 0x40 and halts.
    p_iready = 100;
    for (int i = 0; i < 30; i++) step(0, 32'h0);
    chk("err_pc", last_err_pc, 32'h40);
    chk("err_halt_req", mem_req_valid, 1'b0);
    chk("err_drained", inst_valid, 1'b0);
    step(1, 32'h0);
    chk("resume_valid", mem_req_valid, 1'b1);
    chk("resume_addr", mem_req_addr, 32'h0);
    for (int i = 0; i < 5; i++) step(0, 32'h0);

    // Redirect with three requests outstanding at 3-cycle latency.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 4; i++) step(0, 32'h0);
    step(1, 32'h100);
    for (int i = 0; i < 12; i++) step(0, 32'h0);

    // Misaligned redirect: one fault entry, then fetch stays halted.
    lat_min = 1; lat_max = 1;
    p_iready = 0;
    step(1, 32'h102);
    step(0, 32'h0);
    chk("mis_valid", inst_valid, 1'b1);
    chk("mis_pc", inst_pc, 32'h102);
    chk("mis_data", inst_data, NOP);
    chk("mis_err", inst_err, 1'b1);
    chk("mis_no_req", mem_req_valid, 1'b0);
    p_iready = 100;
    for (int i = 0; i < 5; i++) step(0, 32'h0);

    // Address wrap at the top of the address space.
    step(1, 32'hFFFF_FFF4);
    for (int i = 0; i < 10; i++) step(0, 32'h0);

    // Randomized traffic with redirects, backpressure and variable latency.
    p_ready = 70; p_iready = 60; p_redir = 30; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) step(0, 32'h0);

    // Asynchronous reset mid-operation.
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_valid", mem_req_valid, 1'b0);
    chk("mid_rst_req_addr", mem_req_addr, 32'h0);
    chk("mid_rst_inst_valid", inst_valid, 1'b0);
    chk("mid_rst_inst_pc", inst_pc, 32'h0);
    chk("mid_rst_inst_data", inst_data, NOP);
    chk("mid_rst_inst_err", inst_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
